// File: rtl/token_rewriter.sv
// Rewrites a SEP-delimited word list through a key/replacement vocabulary.
// Hit words emit the replacement, misses are copied verbatim; output ends with an extra SEP.
module token_rewriter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int SEP        = 0,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] voc_base,
   input  logic [ADDR_WIDTH-1:0] voc_last,
   output logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [ADDR_WIDTH-1:0] voc_addr,
   input  logic [DATA_WIDTH-1:0] voc_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_wdata,
   output logic                  out_we,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  hits,
   output logic [CNT_WIDTH-1:0]  misses
);

   // state   | meaning
   // IDLE    | waiting for start
   // INIT    | clear counters/addresses, point at first vocab entry
   // WSTART  | at start of an input word, or at input end
   // CMP     | comparing word against current key
   // SKIPK   | skipping rest of a mismatched key
   // SKIPR   | skipping replacement to reach next entry
   // HIT     | count hit, voc_addr at replacement
   // COPY    | writing replacement symbols
   // MISS    | count miss, rewind to word start
   // COPYW   | writing original word symbols
   // EMIT    | writing word separator
   // TERM    | writing output terminator
   // DONE    | run finished, results held
   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_WSTART, S_CMP, S_SKIPK, S_SKIPR, S_HIT,
      S_COPY, S_MISS, S_COPYW, S_EMIT, S_TERM, S_DONE
   } state_t;

   localparam logic [DATA_WIDTH-1:0] SEP_V = DATA_WIDTH'(SEP);
   localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;
   localparam logic [CNT_WIDTH-1:0]  C_MAX = '1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ws;
   logic [ADDR_WIDTH-1:0] vbase;
   logic [ADDR_WIDTH-1:0] vlast;
   logic [ADDR_WIDTH-1:0] wptr;
   logic                  full;
   logic                  key_start;

   logic                  in_sep, voc_sep, in_end, voc_end;
   logic                  wr_req;
   logic [DATA_WIDTH-1:0] wr_data;

   assign in_sep  = (in_data == SEP_V);
   assign voc_sep = (voc_data == SEP_V);
   assign in_end  = (in_addr == A_MAX);
   assign voc_end = (voc_addr >= vlast);

   always_comb begin
      wr_req  = 1'b0;
      wr_data = SEP_V;
      case (state)
         S_COPY: begin
            wr_req  = !voc_sep;
            wr_data = voc_data;
         end
         S_COPYW: begin
            wr_req  = !in_sep;
            wr_data = in_data;
         end
         S_EMIT, S_TERM: wr_req = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_addr   <= '0;
         voc_addr  <= '0;
         out_addr  <= '0;
         out_wdata <= '0;
         out_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         hits      <= '0;
         misses    <= '0;
         ws        <= '0;
         vbase     <= '0;
         vlast     <= '0;
         wptr      <= '0;
         full      <= 1'b0;
         key_start <= 1'b0;
      end else begin
         out_we <= 1'b0;
         // The last output slot is already used: abort instead of wrapping.
         if (wr_req && full) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
         end else begin
            if (wr_req) begin
               out_we    <= 1'b1;
               out_wdata <= wr_data;
               out_addr  <= wptr;
               if (wptr == A_MAX) full <= 1'b1;
               else               wptr <= wptr + 1'b1;
            end
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     vbase <= voc_base;
                     vlast <= voc_last;
                     done  <= 1'b0;
                     state <= S_INIT;
                  end
               end
               S_INIT: begin
                  hits     <= '0;
                  misses   <= '0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  in_addr  <= '0;
                  voc_addr <= vbase;
                  out_addr <= '0;
                  wptr     <= '0;
                  full     <= 1'b0;
                  ws       <= '0;
                  state    <= S_WSTART;
               end
               S_WSTART: begin
                  if (in_sep || in_end) begin
                     state <= S_TERM;
                  end else begin
                     ws        <= in_addr;
                     voc_addr  <= vbase;
                     key_start <= 1'b1;
                     state     <= (vbase > vlast) ? S_MISS : S_CMP;
                  end
               end
               S_CMP: begin
                  key_start <= 1'b0;
                  if (key_start && voc_sep) begin
                     state <= S_MISS;
                  end else if (in_sep && voc_sep) begin
                     if (voc_addr != A_MAX) voc_addr <= voc_addr + 1'b1;
                     state <= S_HIT;
                  end else if (in_data == voc_data && !in_end && !voc_end) begin
                     in_addr  <= in_addr + 1'b1;
                     voc_addr <= voc_addr + 1'b1;
                  end else begin
                     state <= S_SKIPK;
                  end
               end
               S_SKIPK: begin
                  if (voc_end)      state <= S_MISS;
                  else begin
                     voc_addr <= voc_addr + 1'b1;
                     if (voc_sep) state <= S_SKIPR;
                  end
               end
               S_SKIPR: begin
                  if (voc_end) begin
                     state <= S_MISS;
                  end else begin
                     voc_addr <= voc_addr + 1'b1;
                     if (voc_sep) begin
                        in_addr   <= ws;
                        key_start <= 1'b1;
                        state     <= S_CMP;
                     end
                  end
               end
               S_HIT: begin
                  if (hits != C_MAX) hits <= hits + 1'b1;
                  state <= S_COPY;
               end
               S_COPY: begin
                  if (voc_sep || voc_addr == A_MAX) begin
                     if (!in_end) in_addr <= in_addr + 1'b1;
                     state <= S_EMIT;
                  end else begin
                     voc_addr <= voc_addr + 1'b1;
                  end
               end
               S_MISS: begin
                  if (misses != C_MAX) misses <= misses + 1'b1;
                  in_addr <= ws;
                  state   <= S_COPYW;
               end
               S_COPYW: begin
                  if (!in_end) in_addr <= in_addr + 1'b1;
                  if (in_sep || in_end) state <= S_EMIT;
               end
               S_EMIT: state <= S_WSTART;
               S_TERM: begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
